// File: rtl/alu4_pkg.sv
// alu4_pkg: shared FSM encoding, command field positions and ALU opcodes.
package alu4_pkg;
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  localparam int OP_W = 4;
  localparam logic KIND_EXEC = 1'b0;
  localparam logic KIND_LOAD = 1'b1;
  localparam int UIO_VALID = 0;
  localparam int UIO_KIND = 1;
  localparam int UIO_REP = 2;
  localparam logic [OP_W-1:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBC = 4'd3,
                              OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7,
                              OP_SHL = 4'd8, OP_SHR = 4'd9, OP_ROL = 4'd10, OP_ROR = 4'd11,
                              OP_INC = 4'd12, OP_DEC = 4'd13, OP_MOVB = 4'd14, OP_NAND = 4'd15;
endpackage

// File: rtl/alu4_core.sv
// alu4_core: combinational 4-bit ALU; non-arithmetic ops pass the math carry through,
// non-shift ops pass the rotate carry through.
module alu4_core
  import alu4_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [3:0]      a,
  input  logic [3:0]      b,
  input  logic            math_cin,
  input  logic            rot_cin,
  output logic [3:0]      out,
  output logic            cout,
  output logic            rout,
  output logic            z,
  output logic            v
);
  logic [3:0] bb;
  logic       ci;
  logic       arith;
  logic [4:0] sum;
  assign arith = op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC};
  // every arithmetic op shares one adder: subtraction is a + ~b + carry
  assign bb = (op == OP_SUB || op == OP_SBC) ? ~b : op == OP_INC ? 4'h0 : op == OP_DEC ? 4'hF : b;
  assign ci = (op == OP_ADC || op == OP_SBC) ? math_cin : (op == OP_SUB || op == OP_INC);
  assign sum = {1'b0, a} + {1'b0, bb} + {4'b0, ci};
  always_comb begin
    out = sum[3:0];
    rout = rot_cin;
    case (op)
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      OP_NOT:  out = ~a;
      OP_SHL:  begin out = {a[2:0], 1'b0}; rout = a[3]; end
      OP_SHR:  begin out = {1'b0, a[3:1]}; rout = a[0]; end
      OP_ROL:  begin out = {a[2:0], rot_cin}; rout = a[3]; end
      OP_ROR:  begin out = {rot_cin, a[3:1]}; rout = a[0]; end
      OP_MOVB: out = b;
      OP_NAND: out = ~(a & b);
      default: ;
    endcase
  end
  assign cout = arith ? sum[4] : math_cin;
  assign v = arith & (a[3] == bb[3]) & (sum[3] != a[3]);
  assign z = out == 4'h0;
endmodule

// File: rtl/alu4_sequencer.sv
// alu4_sequencer: accepts LOAD/EXEC commands and iterates the ALU on an accumulator
// with fed-back carry and rotate flags.
module alu4_sequencer
  import alu4_pkg::*;
#(
  parameter int REP_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  state_t state, nxt;
  logic [OP_W-1:0] op_q, opd_q, acc, alu_out;
  logic kind_q, c, r, z, v, alu_c, alu_r, alu_z, alu_v, accept;
  logic [REP_W-1:0] rep_q, cnt;
  logic unused_bits;
  assign unused_bits = ^uio_in[7:UIO_REP+REP_W];
  assign accept = state == IDLE && uio_in[UIO_VALID];
  alu4_core u_core (
    .op(op_q), .a(acc), .b(opd_q), .math_cin(c), .rot_cin(r),
    .out(alu_out), .cout(alu_c), .rout(alu_r), .z(alu_z), .v(alu_v)
  );
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = accept ? DECODE : IDLE;
      DECODE:  nxt = kind_q == KIND_LOAD ? WB : EXEC;
      EXEC:    nxt = cnt == rep_q ? WB : EXEC;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q <= '0;
      opd_q <= '0;
      kind_q <= KIND_EXEC;
      rep_q <= '0;
      cnt <= '0;
      acc <= '0;
      c <= 1'b0;
      r <= 1'b0;
      z <= 1'b1;
      v <= 1'b0;
    end else if (ena) begin
      state <= nxt;
      if (accept) begin
        op_q <= ui_in[7:4];
        opd_q <= ui_in[3:0];
        kind_q <= uio_in[UIO_KIND];
        rep_q <= uio_in[UIO_REP +: REP_W];
      end
      if (state == DECODE) cnt <= '0;
      if (state == EXEC) begin
        acc <= alu_out;
        c <= alu_c;
        r <= alu_r;
        z <= alu_z;
        v <= alu_v;
        // saturate on the last iteration so the counter never wraps within a command
        if (cnt != rep_q) cnt <= cnt + 1'b1;
      end
      if (state == WB && kind_q == KIND_LOAD) begin
        acc <= opd_q;
        z <= opd_q == '0;
      end
    end
  end
  assign uo_out = {v, z, state == WB, state == IDLE, acc};
  assign uio_out = {2'(cnt), r, c, 4'b0000};
  assign uio_oe = 8'hF0;
endmodule

// File: tb/tb_alu4_sequencer.sv
// tb_alu4_sequencer: directed table vectors plus hand-written multi-cycle sequences.
module tb_alu4_sequencer;
  logic clk, rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  int checks = 0;
  int failures = 0;
  logic [3:0] m_acc;
  logic m_c, m_r, m_z, m_v;

  typedef struct {
    logic [3:0] a, op, b;
    logic [1:0] rep;
    logic [3:0] acc;
    logic c, r, z, v;
  } vec_t;
  vec_t tbl[14];

  alu4_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // {v, z, r, c, out}
  function automatic logic [7:0] ref_alu(input logic [3:0] op, a, b, input logic c, r);
    int sa, sb, t, s;
    logic [3:0] o;
    logic co, ro, vo;
    bit ar;
    sa = a >= 8 ? int'(a) - 16 : int'(a);
    sb = b >= 8 ? int'(b) - 16 : int'(b);
    co = c; ro = r; vo = 0; ar = 1; t = 0; s = 0; o = 0;
    case (op)
      4'd0:  begin t = int'(a) + int'(b); s = sa + sb; end
      4'd1:  begin t = int'(a) + int'(b) + int'(c); s = sa + sb + int'(c); end
      4'd2:  begin t = int'(a) - int'(b) + 16; s = sa - sb; end
      4'd3:  begin t = int'(a) - int'(b) - (1 - int'(c)) + 16; s = sa - sb - (1 - int'(c)); end
      4'd12: begin t = int'(a) + 1; s = sa + 1; end
      4'd13: begin t = int'(a) + 15; s = sa - 1; end
      default: ar = 0;
    endcase
    if (ar) begin
      o = 4'(t);
      co = t >= 16;
      vo = s < -8 || s > 7;
    end else
      case (op)
        4'd4:  o = a & b;
        4'd5:  o = a | b;
        4'd6:  o = a ^ b;
        4'd7:  o = 4'(15 - int'(a));
        4'd8:  begin o = 4'(int'(a) * 2); ro = a >= 8; end
        4'd9:  begin o = 4'(int'(a) / 2); ro = a[0]; end
        4'd10: begin o = 4'(int'(a) * 2 + int'(r)); ro = a >= 8; end
        4'd11: begin o = 4'(int'(a) / 2 + (r ? 8 : 0)); ro = a[0]; end
        4'd14: o = b;
        default: o = ~(a & b);
      endcase
    return {vo, o == 0, ro, co, o};
  endfunction

  function automatic logic [7:0] dut_st();
    return {uo_out[7], uo_out[6], uio_out[5], uio_out[4], uo_out[3:0]};
  endfunction

  task automatic apply_reset();
    rst_n = 0; ui_in = 0; uio_in = 0;
    step(); step();
    rst_n = 1;
    m_acc = 0; m_c = 0; m_r = 0; m_v = 0; m_z = 1;
    step();
  endtask

  task automatic run_cmd(input logic kind, input logic [3:0] op, opd, input logic [1:0] rep, input string nm);
    int lat;
    chk({nm, "_ready"}, int'(uo_out[4]), 1);
    ui_in = {op, opd};
    uio_in = {4'b0, rep, kind, 1'b1};
    step();
    uio_in = 8'h00;
    lat = 0;
    while (uo_out[5] !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk({nm, "_latency"}, lat, kind ? 1 : 2 + int'(rep));
    if (kind) begin
      m_acc = opd;
      m_z = opd == 0;
    end else
      for (int i = 0; i <= int'(rep); i++) {m_v, m_z, m_r, m_c, m_acc} = ref_alu(op, m_acc, opd, m_c, m_r);
    step();
    chk({nm, "_done_drop"}, int'(uo_out[5]), 0);
    chk({nm, "_ready_after"}, int'(uo_out[4]), 1);
    chk({nm, "_state"}, int'(dut_st()), int'({m_v, m_z, m_r, m_c, m_acc}));
  endtask

  initial begin
    int lat;
    tbl[0]  = '{4'h5, 4'd0,  4'h3, 2'd0, 4'h8, 0, 0, 0, 1};
    tbl[1]  = '{4'h5, 4'd0,  4'h3, 2'd1, 4'hB, 0, 0, 0, 0};
    tbl[2]  = '{4'h9, 4'd1,  4'h9, 2'd1, 4'hC, 0, 0, 0, 0};
    tbl[3]  = '{4'h3, 4'd2,  4'h3, 2'd0, 4'h0, 1, 0, 1, 0};
    tbl[4]  = '{4'h2, 4'd2,  4'h3, 2'd0, 4'hF, 0, 0, 0, 0};
    tbl[5]  = '{4'h0, 4'd3,  4'h0, 2'd1, 4'hE, 1, 0, 0, 0};
    tbl[6]  = '{4'h6, 4'd10, 4'h0, 2'd3, 4'h3, 0, 0, 0, 0};
    tbl[7]  = '{4'h1, 4'd11, 4'h0, 2'd1, 4'h8, 0, 0, 0, 0};
    tbl[8]  = '{4'hA, 4'd6,  4'hA, 2'd0, 4'h0, 0, 0, 1, 0};
    tbl[9]  = '{4'h8, 4'd13, 4'h0, 2'd0, 4'h7, 1, 0, 0, 1};
    tbl[10] = '{4'hF, 4'd12, 4'h0, 2'd0, 4'h0, 1, 0, 1, 0};
    tbl[11] = '{4'h9, 4'd9,  4'h0, 2'd2, 4'h1, 0, 0, 0, 0};
    tbl[12] = '{4'hC, 4'd15, 4'hA, 2'd0, 4'h7, 0, 0, 0, 0};
    tbl[13] = '{4'h3, 4'd14, 4'hE, 2'd3, 4'hE, 0, 0, 0, 0};

    rst_n = 1; ena = 1; ui_in = 0; uio_in = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_ready", int'(uo_out[4]), 1);
    chk("rst_done", int'(uo_out[5]), 0);
    chk("rst_acc", int'(uo_out[3:0]), 0);
    chk("rst_z", int'(uo_out[6]), 1);
    chk("rst_vrc", int'({uo_out[7], uio_out[5], uio_out[4]}), 0);
    chk("rst_cnt", int'(uio_out[7:6]), 0);
    chk("rst_oe", int'(uio_oe), 8'hF0);
    chk("rst_uio_lo", int'(uio_out[3:0]), 0);
    step(); step();
    rst_n = 1;
    m_acc = 0; m_c = 0; m_r = 0; m_v = 0; m_z = 1;
    step();
    chk("post_rst_ready", int'(uo_out[4]), 1);

    ui_in = 8'h09; uio_in = 8'b0000_0011;
    step();
    uio_in = 0;
    chk("ld9_decode_done", int'(uo_out[5]), 0);
    chk("ld9_decode_ready", int'(uo_out[4]), 0);
    step();
    chk("ld9_done", int'(uo_out[5]), 1);
    step();
    chk("ld9_done_drop", int'(uo_out[5]), 0);
    chk("ld9_acc", int'(uo_out[3:0]), 9);
    chk("ld9_z", int'(uo_out[6]), 0);
    chk("ld9_ready", int'(uo_out[4]), 1);
    m_acc = 9; m_z = 0;

    run_cmd(1, 4'd0, 4'h1, 2'd0, "ld1");
    run_cmd(0, 4'd9, 4'h0, 2'd0, "shr");
    run_cmd(1, 4'd0, 4'h8, 2'd0, "ld8");
    run_cmd(0, 4'd0, 4'h8, 2'd0, "add8");
    chk("pre_ld0_vrc", int'({uo_out[7], uio_out[5], uio_out[4]}), 7);
    run_cmd(1, 4'd0, 4'h0, 2'd0, "ld0");
    chk("ld0_z", int'(uo_out[6]), 1);
    chk("ld0_vrc", int'({uo_out[7], uio_out[5], uio_out[4]}), 7);

    foreach (tbl[i]) begin
      apply_reset();
      run_cmd(1, 4'd0, tbl[i].a, 2'd0, "tbl_ld");
      run_cmd(0, tbl[i].op, tbl[i].b, tbl[i].rep, "tbl_exec");
      chk($sformatf("tbl%0d_acc", i), int'(uo_out[3:0]), int'(tbl[i].acc));
      chk($sformatf("tbl%0d_crzv", i), int'({uio_out[4], uio_out[5], uo_out[6], uo_out[7]}),
          int'({tbl[i].c, tbl[i].r, tbl[i].z, tbl[i].v}));
    end

    apply_reset();
    for (int op = 0; op < 16; op++) begin
      run_cmd(1, 4'd0, 4'h5, 2'd0, "sweep_ld");
      run_cmd(0, 4'(op), 4'hB, 2'd3, $sformatf("sweep_op%0d", op));
    end

    apply_reset();
    run_cmd(1, 4'd0, 4'h5, 2'd0, "mid_ld");
    ui_in = 8'h01; uio_in = 8'b0000_1101;
    step();
    uio_in = 0;
    step(); step();
    chk("mid_acc", int'(uo_out[3:0]), 6);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_ready", int'(uo_out[4]), 1);
    chk("mid_rst_done", int'(uo_out[5]), 0);
    chk("mid_rst_acc", int'(uo_out[3:0]), 0);
    chk("mid_rst_z", int'(uo_out[6]), 1);
    chk("mid_rst_vrc", int'({uo_out[7], uio_out[5], uio_out[4]}), 0);
    chk("mid_rst_cnt", int'(uio_out[7:6]), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_no_done", int'(uo_out[5]), 0);
    end
    rst_n = 1;
    step();
    chk("mid_rel_ready", int'(uo_out[4]), 1);
    chk("mid_rel_done", int'(uo_out[5]), 0);
    m_acc = 0; m_c = 0; m_r = 0; m_v = 0; m_z = 1;

    apply_reset();
    ui_in = 8'hC0; uio_in = 8'b0000_0101;
    step();
    for (int i = 1; i <= 9; i++) begin
      step();
      chk($sformatf("busy_ready_%0d", i), int'(uo_out[4]), int'(i % 5 == 4));
      chk($sformatf("busy_done_%0d", i), int'(uo_out[5]), int'(i % 5 == 3));
      if (i == 3) chk("busy_acc_first", int'(uo_out[3:0]), 2);
      if (i == 9) uio_in = 0;
    end
    step();
    chk("busy_idle_ready", int'(uo_out[4]), 1);
    chk("busy_acc_second", int'(uo_out[3:0]), 4);

    apply_reset();
    run_cmd(1, 4'd0, 4'h5, 2'd0, "nostall_ld");
    run_cmd(0, 4'd1, 4'hB, 2'd3, "nostall");
    chk("nostall_acc", int'(uo_out[3:0]), 3);
    chk("nostall_crzv", int'({uio_out[4], uio_out[5], uo_out[6], uo_out[7]}), 4'b1000);
    apply_reset();
    run_cmd(1, 4'd0, 4'h5, 2'd0, "stall_ld");
    ui_in = 8'h1B; uio_in = 8'b0000_1101;
    step();
    uio_in = 0;
    step(); step();
    ena = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_acc", int'(uo_out[3:0]), 0);
      chk("stall_crzv", int'({uio_out[4], uio_out[5], uo_out[6], uo_out[7]}), 4'b1010);
      chk("stall_cnt", int'(uio_out[7:6]), 1);
      chk("stall_done", int'(uo_out[5]), 0);
    end
    ena = 1;
    lat = 0;
    while (uo_out[5] !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk("stall_resume_latency", lat, 3);
    step();
    chk("stall_final_acc", int'(uo_out[3:0]), 3);
    chk("stall_final_crzv", int'({uio_out[4], uio_out[5], uo_out[6], uo_out[7]}), 4'b1000);

    ena = 0; ui_in = 8'h07; uio_in = 8'b0000_0011;
    step(); step();
    uio_in = 0;
    ena = 1;
    step();
    chk("ena_low_cmd_ready", int'(uo_out[4]), 1);
    chk("ena_low_cmd_acc", int'(uo_out[3:0]), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
